// File: rtl/reg_stack_ctrl_pkg.sv
// Shared widths, stack size, sequencer state encoding and register range check
// for the register stack sequencer.
package reg_stack_ctrl_pkg;

  localparam int NIB_SIZE       = 4;
  localparam int WORD_SIZE      = 16;
  localparam int REG_STACK_SIZE = 16;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_DONE,
    R_SETUP,
    R_PULSE,
    R_CAPTURE,
    R_DONE
  } state_t;

  function automatic logic in_range(input logic [NIB_SIZE-1:0] num, input int size);
    return int'(num) < size;
  endfunction

endpackage

// File: rtl/reg_bypass_shadow.sv
// Shadow copy {valid, num, val} of the last completed in-range stack write, with
// compare against both latched read operand numbers.
module reg_bypass_shadow
  import reg_stack_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [NIB_SIZE-1:0]  wr_num,
  input  logic [WORD_SIZE-1:0] wr_val,
  input  logic [NIB_SIZE-1:0]  num1,
  input  logic [NIB_SIZE-1:0]  num2,
  output logic                 hit1,
  output logic                 hit2,
  output logic [WORD_SIZE-1:0] val
);

  logic                valid;
  logic [NIB_SIZE-1:0] num;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      num   <= '0;
      val   <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      num   <= wr_num;
      val   <= wr_val;
    end
  end

  assign hit1 = valid && (num1 == num);
  assign hit2 = valid && (num2 == num);

endmodule

// File: rtl/reg_stack_ctrl.sv
// Serialises operand reads and write-backs onto the register stack strobes.
// REG_BYPASS_EN adds a last-write shadow that short-circuits fully matching reads.
module reg_stack_ctrl
  import reg_stack_ctrl_pkg::*;
#(
  parameter int STACK_SIZE = REG_STACK_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rd_req,
  input  logic [NIB_SIZE-1:0]  rd_num1,
  input  logic [NIB_SIZE-1:0]  rd_num2,
  output logic                 rd_ack,
  output logic [WORD_SIZE-1:0] rd_val1,
  output logic [WORD_SIZE-1:0] rd_val2,
  input  logic                 wr_req,
  input  logic [NIB_SIZE-1:0]  wr_num,
  input  logic [WORD_SIZE-1:0] wr_val,
  output logic                 wr_ack,
  output logic [NIB_SIZE-1:0]  rs_num1,
  output logic [NIB_SIZE-1:0]  rs_num2,
  output logic [NIB_SIZE-1:0]  rs_setnum,
  output logic [WORD_SIZE-1:0] rs_setval,
  output logic                 rs_get_clk,
  output logic                 rs_set_clk,
  input  logic [WORD_SIZE-1:0] rs_out1,
  input  logic [WORD_SIZE-1:0] rs_out2,
  output logic                 busy
);

  state_t               state;
  logic                 last_was_write;
  logic                 can_accept, take_rd, take_wr;
  logic                 hit1, hit2;
  logic [WORD_SIZE-1:0] shadow_val;
  logic [WORD_SIZE-1:0] val1_sel, val2_sel;

`ifdef REG_BYPASS_EN
  // rs_set_clk is only raised for in-range writes, so it doubles as the shadow load enable.
  reg_bypass_shadow u_shadow (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (rs_set_clk),
    .wr_num  (rs_setnum),
    .wr_val  (rs_setval),
    .num1    (rs_num1),
    .num2    (rs_num2),
    .hit1    (hit1),
    .hit2    (hit2),
    .val     (shadow_val)
  );
`else
  assign hit1       = 1'b0;
  assign hit2       = 1'b0;
  assign shadow_val = '0;
`endif

  // The DONE states accept like IDLE; the flag is already updated on entry to them.
  always_comb begin
    can_accept = (state == IDLE) || (state == W_DONE) || (state == R_DONE);
    take_rd    = can_accept && rd_req && (!wr_req || last_was_write);
    take_wr    = can_accept && wr_req && !take_rd;
    val1_sel   = hit1 ? shadow_val : (in_range(rs_num1, STACK_SIZE) ? rs_out1 : '0);
    val2_sel   = hit2 ? shadow_val : (in_range(rs_num2, STACK_SIZE) ? rs_out2 : '0);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_was_write <= 1'b0;
      rd_ack         <= 1'b0;
      wr_ack         <= 1'b0;
      rs_get_clk     <= 1'b0;
      rs_set_clk     <= 1'b0;
      rd_val1        <= '0;
      rd_val2        <= '0;
      rs_num1        <= '0;
      rs_num2        <= '0;
      rs_setnum      <= '0;
      rs_setval      <= '0;
    end else begin
      rd_ack     <= 1'b0;
      wr_ack     <= 1'b0;
      rs_get_clk <= 1'b0;
      rs_set_clk <= 1'b0;
      case (state)
        W_SETUP: begin
          state      <= W_PULSE;
          rs_set_clk <= in_range(rs_setnum, STACK_SIZE);
        end
        W_PULSE: begin
          state          <= W_DONE;
          wr_ack         <= 1'b1;
          last_was_write <= 1'b1;
        end
        R_SETUP: begin
          if (hit1 && hit2) begin
            state          <= R_DONE;
            rd_ack         <= 1'b1;
            last_was_write <= 1'b0;
            rd_val1        <= shadow_val;
            rd_val2        <= shadow_val;
          end else begin
            state      <= R_PULSE;
            rs_get_clk <= 1'b1;
          end
        end
        R_PULSE: state <= R_CAPTURE;
        R_CAPTURE: begin
          state          <= R_DONE;
          rd_ack         <= 1'b1;
          last_was_write <= 1'b0;
          rd_val1        <= val1_sel;
          rd_val2        <= val2_sel;
        end
        default: begin
          if (take_wr) begin
            state     <= W_SETUP;
            rs_setnum <= wr_num;
            rs_setval <= wr_val;
          end else if (take_rd) begin
            state   <= R_SETUP;
            rs_num1 <= rd_num1;
            rs_num2 <= rd_num2;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_stack_ctrl.sv
// Directed bench for reg_stack_ctrl with a behavioural stack model on the strobes.
// Built with an 8-entry stack so that r15 is out of range.
module tb_reg_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_num1 = '0, rd_num2 = '0;
  logic        rd_ack;
  logic [15:0] rd_val1, rd_val2;
  logic        wr_req = 1'b0;
  logic [3:0]  wr_num = '0;
  logic [15:0] wr_val = '0;
  logic        wr_ack;
  logic [3:0]  rs_num1, rs_num2, rs_setnum;
  logic [15:0] rs_setval;
  logic        rs_get_clk, rs_set_clk;
  logic [15:0] rs_out1 = '0, rs_out2 = '0;
  logic        busy;

  logic [15:0] mem [16];
  int set_cnt = 0;
  int get_cnt = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_stack_ctrl #(.STACK_SIZE(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_num1(rd_num1), .rd_num2(rd_num2),
    .rd_ack(rd_ack), .rd_val1(rd_val1), .rd_val2(rd_val2),
    .wr_req(wr_req), .wr_num(wr_num), .wr_val(wr_val), .wr_ack(wr_ack),
    .rs_num1(rs_num1), .rs_num2(rs_num2), .rs_setnum(rs_setnum), .rs_setval(rs_setval),
    .rs_get_clk(rs_get_clk), .rs_set_clk(rs_set_clk),
    .rs_out1(rs_out1), .rs_out2(rs_out2), .busy(busy)
  );

  always @(posedge rs_set_clk) begin
    mem[rs_setnum] = rs_setval;
    set_cnt++;
  end

  always @(posedge rs_get_clk) begin
    rs_out1 = mem[rs_num1];
    rs_out2 = mem[rs_num2];
    get_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_op(input logic [3:0] n, input logic [15:0] v, output int lat);
    wr_num = n; wr_val = v; wr_req = 1'b1; lat = 0;
    do begin tick(); lat++; end while (!wr_ack && lat < 20);
    wr_req = 1'b0;
    checks++;
    if (wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL write_timeout num=%0d wr_ack=%b, required ack within 20 cycles", n, wr_ack);
    end
  endtask

  task automatic read_op(input logic [3:0] n1, input logic [3:0] n2, output int lat,
                         output logic [15:0] v1, output logic [15:0] v2);
    rd_num1 = n1; rd_num2 = n2; rd_req = 1'b1; lat = 0;
    do begin tick(); lat++; end while (!rd_ack && lat < 20);
    rd_req = 1'b0;
    v1 = rd_val1; v2 = rd_val2;
    checks++;
    if (rd_ack !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout nums=%0d,%0d rd_ack=%b, required ack within 20 cycles", n1, n2, rd_ack);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({rd_ack, wr_ack, busy, rs_get_clk, rs_set_clk} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=00000", {rd_ack, wr_ack, busy, rs_get_clk, rs_set_clk});
    end
    checks++;
    if ({rd_val1, rd_val2, rs_num1, rs_num2, rs_setnum, rs_setval} !== 60'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", {rd_val1, rd_val2, rs_num1, rs_num2, rs_setnum, rs_setval});
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_write();
    int s0;
    s0 = set_cnt;
    wr_num = 4'd3; wr_val = 16'h1234; wr_req = 1'b1;
    tick();
    checks++;
    if ({busy, rs_set_clk, rs_setnum, rs_setval} !== {1'b1, 1'b0, 4'd3, 16'h1234}) begin
      errors++;
      $display("FAIL write_setup busy/set_clk/num/val got=%b/%b/%0d/%h want=1/0/3/1234",
               busy, rs_set_clk, rs_setnum, rs_setval);
    end
    tick();
    checks++;
    if ({rs_set_clk, wr_ack} !== 2'b10) begin
      errors++;
      $display("FAIL write_pulse set_clk,wr_ack got=%b want=10", {rs_set_clk, wr_ack});
    end
    tick();
    checks++;
    if ({rs_set_clk, wr_ack} !== 2'b01) begin
      errors++;
      $display("FAIL write_done set_clk,wr_ack got=%b want=01", {rs_set_clk, wr_ack});
    end
    wr_req = 1'b0;
    tick();
    checks++;
    if ({wr_ack, busy} !== 2'b00) begin
      errors++;
      $display("FAIL write_idle wr_ack,busy got=%b want=00", {wr_ack, busy});
    end
    checks++;
    if (set_cnt - s0 != 1 || mem[3] !== 16'h1234) begin
      errors++;
      $display("FAIL write_strobe pulses=%0d mem3=%h want 1 pulse, 1234", set_cnt - s0, mem[3]);
    end
  endtask

  task automatic test_read();
    int lat, g0;
    logic [15:0] v1, v2;
    g0 = get_cnt;
    read_op(4'd3, 4'd0, lat, v1, v2);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL read_latency got=%0d want=4", lat);
    end
    checks++;
    if (v1 !== 16'h1234 || v2 !== 16'h0000) begin
      errors++;
      $display("FAIL read_values got=%h,%h want=1234,0000", v1, v2);
    end
    tick();
    checks++;
    if (rd_ack !== 1'b0 || rd_val1 !== 16'h1234 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_hold ack=%b val1=%h busy=%b want 0,1234,0", rd_ack, rd_val1, busy);
    end
    checks++;
    if (get_cnt - g0 != 1) begin
      errors++;
      $display("FAIL read_get_pulses got=%0d want=1", get_cnt - g0);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0]  order;
    logic [15:0] first_v1, first_v2;
    int events, cyc;
    order = '0; events = 0; cyc = 0; first_v1 = '0; first_v2 = '0;
    wr_num = 4'd7; wr_val = 16'hBEEF; rd_num1 = 4'd7; rd_num2 = 4'd3;
    wr_req = 1'b1; rd_req = 1'b1;
    while (events < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (wr_ack) begin order = {order[2:0], 1'b1}; events++; end
      if (rd_ack) begin
        order = {order[2:0], 1'b0};
        events++;
        if (events == 2) begin first_v1 = rd_val1; first_v2 = rd_val2; end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    checks++;
    if (events != 4 || order !== 4'b1010) begin
      errors++;
      $display("FAIL arb_order events=%0d order=%b want 4 events, 1010 (W,R,W,R)", events, order);
    end
    checks++;
    if (first_v1 !== 16'hBEEF || first_v2 !== 16'h1234) begin
      errors++;
      $display("FAIL arb_read_value got=%h,%h want=beef,1234", first_v1, first_v2);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL arb_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic test_out_of_range();
    int lat, s0;
    logic [15:0] v1, v2;
    s0 = set_cnt;
    write_op(4'd15, 16'hFFFF, lat);
    checks++;
    if (lat != 3 || set_cnt != s0) begin
      errors++;
      $display("FAIL oor_write lat=%0d pulses=%0d want lat 3, 0 pulses", lat, set_cnt - s0);
    end
    tick();
    read_op(4'd15, 4'd3, lat, v1, v2);
    checks++;
    if (lat != 4 || v1 !== 16'h0000 || v2 !== 16'h1234) begin
      errors++;
      $display("FAIL oor_read lat=%0d vals=%h,%h want 4, 0000,1234", lat, v1, v2);
    end
    tick();
  endtask

  task automatic test_reset_in_pulse();
    int lat;
    logic [15:0] v1, v2;
    wr_num = 4'd6; wr_val = 16'h0666; wr_req = 1'b1;
    tick();
    tick();
    checks++;
    if (rs_set_clk !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_pulse set_clk got=%b want=1", rs_set_clk);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({rs_set_clk, busy, wr_ack, rd_ack, rs_get_clk} !== 5'b0) begin
      errors++;
      $display("FAIL rst_async_ctrl got=%b want=00000", {rs_set_clk, busy, wr_ack, rd_ack, rs_get_clk});
    end
    checks++;
    if ({rd_val1, rd_val2, rs_num1, rs_num2, rs_setnum, rs_setval} !== 60'h0) begin
      errors++;
      $display("FAIL rst_async_data got=%h want=0", {rd_val1, rd_val2, rs_num1, rs_num2, rs_setnum, rs_setval});
    end
    wr_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    read_op(4'd6, 4'd7, lat, v1, v2);
    checks++;
    if (lat != 4 || v1 !== 16'h0666 || v2 !== 16'hBEEF) begin
      errors++;
      $display("FAIL rst_stack_kept lat=%0d vals=%h,%h want 4, 0666,beef", lat, v1, v2);
    end
    tick();
    read_op(4'd7, 4'd7, lat, v1, v2);
    checks++;
    if (lat != 4 || v1 !== 16'hBEEF) begin
      errors++;
      $display("FAIL rst_shadow_cleared lat=%0d val=%h want 4, beef", lat, v1);
    end
    tick();
  endtask

  task automatic test_bypass();
    int lat, g0, exp_lat, exp_get;
    logic [15:0] v1, v2;
`ifdef REG_BYPASS_EN
    exp_lat = 2; exp_get = 0;
`else
    exp_lat = 4; exp_get = 1;
`endif
    write_op(4'd5, 16'h00AA, lat);
    tick();
    g0 = get_cnt;
    read_op(4'd5, 4'd5, lat, v1, v2);
    checks++;
    if (lat != exp_lat || get_cnt - g0 != exp_get) begin
      errors++;
      $display("FAIL bypass_timing lat=%0d pulses=%0d want %0d, %0d", lat, get_cnt - g0, exp_lat, exp_get);
    end
    checks++;
    if (v1 !== 16'h00AA || v2 !== 16'h00AA) begin
      errors++;
      $display("FAIL bypass_values got=%h,%h want=00aa,00aa", v1, v2);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[15] = 16'h5A5A;
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_out_of_range();
    test_reset_in_pulse();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
